// File: rtl/button_event_gen.sv
// button_event_gen: debounced level (clk, async-high rst, debounced) -> registered press/release/long/repeat pulses and held level
module button_event_gen #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  typedef enum logic [1:0] {IDLE, PRESSED, HOLD} state_t;
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic armed;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      armed         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (state == IDLE && !debounced) armed <= 1'b1;
      case (state)
        IDLE: if (debounced && armed) begin
          state       <= PRESSED;
          cnt         <= '0;
          press_pulse <= 1'b1;
        end
        PRESSED: if (!debounced) begin
          state         <= IDLE;
          cnt           <= '0;
          release_pulse <= 1'b1;
        end else if (cnt == LONG_MAX) begin
          state      <= HOLD;
          cnt        <= '0;
          long_pulse <= 1'b1;
          held       <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        HOLD: if (!debounced) begin
          state         <= IDLE;
          cnt           <= '0;
          release_pulse <= 1'b1;
          held          <= 1'b0;
        end else if (cnt == REP_MAX) begin
          cnt          <= '0;
          repeat_pulse <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Sits directly downstream of the debouncer. Consumes one clean, same-clock-domain debounced button level and produces single-cycle event pulses: press, release, long-press, and auto-repeat.
- Feeds the microwave control FSM, e.g. for hold-to-increment time entry, and provides a held level for display/cancel logic.

Parameters:
- LONG_CYCLES, default 50000000: cycles the button must stay pressed before long_pulse fires; legal range >= 2.
- REPEAT_CYCLES, default 10000000: period between repeat_pulse events once held; legal range >= 1.
- CNT_W, default 26: hold counter width; must represent max(LONG_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- debounced  input  1  clean button level from the debouncer; 1 = pressed; synchronous to clk.
- press_pulse  output  1  one-cycle pulse on an accepted press.
- release_pulse  output  1  one-cycle pulse on release of an accepted press.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in long-hold.
- held  output  1  level; 1 from long_pulse until release.

Behaviour:
- Reset: state=IDLE, cnt=0, armed=0. All outputs 0 immediately (async) and while rst=1.
- All outputs are registered. A sample taken at edge k produces an output visible after edge k. Pulses are exactly 1 cycle wide.
- armed: set at any edge where state=IDLE and debounced=0. A button already held through reset produces no events until it has been released once.
- IDLE:
  - debounced=1 and armed=1 -> PRESSED, cnt=0, press_pulse=1.
  - debounced=1 and armed=0 -> stay IDLE, no output.
- PRESSED:
  - debounced=0 -> IDLE, release_pulse=1, cnt=0.
  - Else if cnt==LONG_CYCLES-1 -> HELD, long_pulse=1, held=1, cnt=0.
  - Else cnt++.
- HELD:
  - debounced=0 -> IDLE, release_pulse=1, held=0, cnt=0.
  - Else if cnt==REPEAT_CYCLES-1 -> repeat_pulse=1, cnt=0.
  - Else cnt++.
- Timing: with press accepted at edge k and the level held,
  - long_pulse follows edge k+LONG_CYCLES.
  - repeat_pulse follows edges k+LONG_CYCLES+n*REPEAT_CYCLES, n>=1.
  - REPEAT_CYCLES=1 gives repeat_pulse every cycle while held.
- Simultaneous events: release in the same cycle the threshold compare is true -> release wins. Only release_pulse fires; no long_pulse or repeat_pulse.
- At most one of press_pulse/release_pulse/long_pulse/repeat_pulse is 1 in any cycle.
- Counter never wraps: it is cleared on every threshold hit and on every state change.
- Reset mid-operation (any state): immediate return to IDLE with armed=0. No release_pulse is generated for the aborted press.
- One-cycle press (debounced high for 1 sample): press_pulse, then release_pulse in the next cycle.

Test Plan:
- All scenarios: LONG_CYCLES=20, REPEAT_CYCLES=8, clk period 10 ns.
- Reset then short press: rst=1 for 10 ns, debounced=0 for 30 ns, then 1 for 50 ns, then 0 -> exactly one press_pulse and one release_pulse. No long_pulse; held stays 0.
- Long hold: debounced=1 for 400 ns -> press_pulse at accept edge k; long_pulse and held=1 at k+20; repeat_pulse at k+28, k+36. Release -> release_pulse, held=0.
- Threshold race: debounced falls on exactly the sample where cnt==19 -> release_pulse only; long_pulse never asserts.
- Held through reset: debounced=1 before and during rst deassert -> no pulses. Then debounced=0 for 20 ns and 1 again -> press_pulse.
- Reset mid-hold: assert rst while held=1 -> all outputs 0 within the same cycle, no release_pulse. After rst deasserts with debounced=1, no press_pulse until a release is seen.
- Toggling input: debounced alternates every cycle for 15 cycles -> press_pulse/release_pulse alternate. Pulse counts match the rising/falling edge counts; no long_pulse; never two pulses in one cycle.
